// File: rtl/g15_io_pkg.sv
// Shared G-15 I/O types: destination tags, 5-bit character codes, the
// tagged character record carried through the character FIFO, and the
// slow-output receiver FSM state encoding.
package g15_io_pkg;

  typedef enum logic [1:0] {
    DEST_TYPE       = 2'd0,
    DEST_TAPE_PUNCH = 2'd1,
    DEST_CARD_PUNCH = 2'd2
  } io_dest_t;

  typedef logic [4:0] g15_char_t;

  typedef struct packed {
    io_dest_t  dest;
    g15_char_t code;
  } io_char_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    BUSY    = 2'd2
  } rx_state_t;

  // Card punch wins over tape punch; neither selected means typewriter.
  function automatic io_dest_t decode_dest(input logic card, input logic punch);
    io_dest_t d;
    d = DEST_TYPE;
    if (card) d = DEST_CARD_PUNCH;
    else if (punch) d = DEST_TAPE_PUNCH;
    return d;
  endfunction

endpackage

// File: rtl/io_char_fifo.sv
// Synchronous FIFO of tagged G-15 characters. Shared by the slow-output
// receiver and intended for the photo-reader side as well.
// Handshake: a pop is honoured only when not empty; a push is accepted when
// not full, or when full and a pop happens on the same clock (the pop frees
// the slot). No bypass: data pushed into an empty FIFO appears on dout the
// following clock.
module io_char_fifo
  import g15_io_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  io_char_t                 din,
  output io_char_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  io_char_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_pop;
  logic            do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/slow_out_rx.sv
// Device-side receiver for the G-15 slow-output path. Detects TYPE_PULSE
// rising edges on CLOCK_TICK, captures the 5-bit code and destination,
// queues it for the host and reports mechanism busy time as DEVICE_BUSY.
// Optional feature macro: SLOW_OUT_RX_CHAR_COUNT_EN adds char_total, a
// 16-bit wrapping count of characters accepted into the FIFO.
// Host handshake: char_valid/char_ready, transfer when both are high;
// char_code/char_dest hold while char_valid & ~char_ready.
module slow_out_rx
  import g15_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TYPE_TICKS = 6
) (
  input  logic                          CLK,
  input  logic                          rst_n,
  input  logic                          CLOCK_TICK,
  input  logic                          TYPE_PULSE,
  input  logic                          PUNCH_SIGNAL,
  input  logic                          CARD_PUNCH_SIGNAL,
  input  logic                          MAG1_OUT,
  input  logic                          MAG2_OUT,
  input  logic                          MAG3_OUT,
  input  logic                          MAG4_OUT,
  input  logic                          MAG5_OUT,
  output logic                          char_valid,
  input  logic                          char_ready,
  output logic [4:0]                    char_code,
  output logic [1:0]                    char_dest,
  output logic                          DEVICE_BUSY,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
`ifdef SLOW_OUT_RX_CHAR_COUNT_EN
  output logic [15:0]                   char_total,
`endif
  output logic [1:0]                    fsm_state
);

  rx_state_t  state;
  rx_state_t  state_next;
  logic       tp_q;
  logic       edge_det;
  io_char_t   cap_q;
  io_char_t   head;
  logic [7:0] busy_cnt;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;

  assign edge_det = CLOCK_TICK & TYPE_PULSE & ~tp_q;

  // TYPE_PULSE history, advanced only on bit-time ticks.
  always_ff @(posedge CLK) begin
    if (!rst_n) tp_q <= 1'b0;
    else if (CLOCK_TICK) tp_q <= TYPE_PULSE;
  end

  // Latch code and destination on the detected strobe edge.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      cap_q <= '0;
    end else if (edge_det) begin
      cap_q.dest <= decode_dest(CARD_PUNCH_SIGNAL, PUNCH_SIGNAL);
      cap_q.code <= {MAG5_OUT, MAG4_OUT, MAG3_OUT, MAG2_OUT, MAG1_OUT};
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  end

  // Next state: an edge during BUSY is still captured (restarts busy time).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (edge_det) state_next = CAPTURE;
      CAPTURE: state_next = BUSY;
      BUSY: begin
        if (edge_det) state_next = CAPTURE;
        else if (CLOCK_TICK && busy_cnt <= 8'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Busy time: reload when a character is pushed, count ticks down in BUSY.
  always_ff @(posedge CLK) begin
    if (!rst_n) busy_cnt <= '0;
    else if (state == CAPTURE) busy_cnt <= 8'(TYPE_TICKS);
    else if (state == BUSY && CLOCK_TICK && busy_cnt != '0) busy_cnt <= busy_cnt - 8'd1;
  end

  assign push = (state == CAPTURE);
  assign pop  = char_valid & char_ready;

  io_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (cap_q),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign char_valid  = ~empty;
  assign char_code   = empty ? 5'd0 : head.code;
  assign char_dest   = empty ? 2'd0 : head.dest;
  assign DEVICE_BUSY = (state != IDLE);
  assign fsm_state   = state;

  // Sticky loss flag: push into a full FIFO with no pop to make room.
  always_ff @(posedge CLK) begin
    if (!rst_n) overflow <= 1'b0;
    else if (push && full && !pop) overflow <= 1'b1;
  end

`ifdef SLOW_OUT_RX_CHAR_COUNT_EN
  // Count characters actually accepted into the FIFO; wraps at 16 bits.
  always_ff @(posedge CLK) begin
    if (!rst_n) char_total <= '0;
    else if (push && (!full || pop)) char_total <= char_total + 16'd1;
  end
`endif

endmodule

// File: tb/tb_slow_out_rx.sv
// Bench for slow_out_rx: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based model.
`timescale 1ns/1ps
module tb_slow_out_rx;
  import g15_io_pkg::*;

  localparam int DEPTH = 8;
  localparam int TICKS = 6;

  // Clock and reset
  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  logic       tick = 1'b0;
  logic       tp = 1'b0;
  logic       punch = 1'b0;
  logic       card = 1'b0;
  logic [4:0] mag = 5'd0;
  logic       char_ready = 1'b0;
  logic       char_valid;
  logic [4:0] char_code;
  logic [1:0] char_dest;
  logic       DEVICE_BUSY;
  logic       overflow;
  logic [3:0] fifo_count;
  logic [1:0] fsm_state;
`ifdef SLOW_OUT_RX_CHAR_COUNT_EN
  logic [15:0] char_total;
`endif

  slow_out_rx #(.FIFO_DEPTH(DEPTH), .TYPE_TICKS(TICKS)) dut (
    .CLK               (CLK),
    .rst_n             (rst_n),
    .CLOCK_TICK        (tick),
    .TYPE_PULSE        (tp),
    .PUNCH_SIGNAL      (punch),
    .CARD_PUNCH_SIGNAL (card),
    .MAG1_OUT          (mag[0]),
    .MAG2_OUT          (mag[1]),
    .MAG3_OUT          (mag[2]),
    .MAG4_OUT          (mag[3]),
    .MAG5_OUT          (mag[4]),
    .char_valid        (char_valid),
    .char_ready        (char_ready),
    .char_code         (char_code),
    .char_dest         (char_dest),
    .DEVICE_BUSY       (DEVICE_BUSY),
    .overflow          (overflow),
    .fifo_count        (fifo_count),
`ifdef SLOW_OUT_RX_CHAR_COUNT_EN
    .char_total        (char_total),
`endif
    .fsm_state         (fsm_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of {dest,code}, pending capture, ticks left busy.
  logic [6:0]  exp_q[$];
  bit          m_over = 1'b0;
  bit          m_cap = 1'b0;
  bit          m_tp = 1'b0;
  int          m_rem = 0;
  logic [6:0]  m_pend = '0;
  int          m_total = 0;

  always @(posedge CLK) begin
    bit edge_seen;
    int dest;
    if (!rst_n) begin
      exp_q.delete();
      m_over = 1'b0; m_cap = 1'b0; m_tp = 1'b0; m_rem = 0; m_pend = '0; m_total = 0;
    end else begin
      if (exp_q.size() > 0 && char_ready) void'(exp_q.pop_front());
      if (m_cap) begin
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(m_pend);
          m_total = (m_total + 1) % 65536;
        end else begin
          m_over = 1'b1;
        end
      end
      if (m_cap) m_rem = TICKS;
      else if (tick && m_rem > 0) m_rem = m_rem - 1;
      edge_seen = tick && tp && !m_tp;
      if (tick) m_tp = tp;
      if (edge_seen) begin
        dest = card ? 2 : (punch ? 1 : 0);
        m_pend = {2'(dest), mag};
      end
      m_cap = edge_seen;
    end
  end

  // Scoreboard: compare every cycle on the falling edge.
  always @(negedge CLK) begin
    int n;
    n = exp_q.size();
    check("m_valid", int'(char_valid), int'(n != 0));
    check("m_count", int'(fifo_count), n);
    check("m_code", int'(char_code), (n != 0) ? int'(exp_q[0][4:0]) : 0);
    check("m_dest", int'(char_dest), (n != 0) ? int'(exp_q[0][6:5]) : 0);
    check("m_busy", int'(DEVICE_BUSY), int'(m_cap || m_rem > 0));
    check("m_overflow", int'(overflow), int'(m_over));
`ifdef SLOW_OUT_RX_CHAR_COUNT_EN
    check("m_total", int'(char_total), m_total);
`endif
  end

  // Driver tasks
  task automatic clk_cycle(input bit t);
    tick = t;
    @(posedge CLK);
    #1;
    tick = 1'b0;
  endtask

  task automatic send_char(input logic [4:0] code, input bit p, input bit c, input bit rdy_at_push);
    mag = code; punch = p; card = c; tp = 1'b1;
    clk_cycle(1'b1);
    char_ready = rdy_at_push; tp = 1'b0;
    clk_cycle(1'b0);
    char_ready = 1'b0;
    clk_cycle(1'b1);
  endtask

  task automatic pop_one();
    char_ready = 1'b1;
    clk_cycle(1'b0);
    char_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tp = 1'b0;
    clk_cycle(1'b0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0] code;
    bit         p;
    bit         c;
    logic [1:0] dest;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n_busy;
    vecs[0] = '{code: 5'h03, p: 1'b1, c: 1'b1, dest: 2'd2};
    vecs[1] = '{code: 5'h03, p: 1'b1, c: 1'b0, dest: 2'd1};
    vecs[2] = '{code: 5'h1F, p: 1'b0, c: 1'b1, dest: 2'd2};
    vecs[3] = '{code: 5'h00, p: 1'b0, c: 1'b0, dest: 2'd0};
    vecs[4] = '{code: 5'h0A, p: 1'b1, c: 1'b0, dest: 2'd1};

    repeat (2) clk_cycle(1'b0);
    rst_n = 1'b1;

    // Reset state
    check("rst_valid", int'(char_valid), 0);
    check("rst_code", int'(char_code), 0);
    check("rst_dest", int'(char_dest), 0);
    check("rst_busy", int'(DEVICE_BUSY), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_state", int'(fsm_state), int'(IDLE));
`ifdef SLOW_OUT_RX_CHAR_COUNT_EN
    check("rst_total", int'(char_total), 0);
`endif

    // Single character: 2-CLK latency and busy for TICKS ticks
    mag = 5'b10110; punch = 1'b0; card = 1'b0; tp = 1'b1;
    clk_cycle(1'b1);
    check("lat1_valid", int'(char_valid), 0);
    check("lat1_busy", int'(DEVICE_BUSY), 1);
    tp = 1'b0;
    clk_cycle(1'b0);
    check("lat2_valid", int'(char_valid), 1);
    check("lat2_code", int'(char_code), 'h16);
    check("lat2_dest", int'(char_dest), 0);
    n_busy = 0;
    for (int i = 0; i < 200; i++) begin
      bit t;
      t = (i % 3 == 2);
      if (!DEVICE_BUSY) break;
      if (t) n_busy++;
      clk_cycle(t);
    end
    check("busy_ticks", n_busy, TICKS);
    check("busy_dropped", int'(DEVICE_BUSY), 0);
    pop_one();
    check("lat_drained", int'(fifo_count), 0);

    // Destination vector table
    foreach (vecs[k]) begin
      send_char(vecs[k].code, vecs[k].p, vecs[k].c, 1'b0);
      check("vec_valid", int'(char_valid), 1);
      check("vec_code", int'(char_code), int'(vecs[k].code));
      check("vec_dest", int'(char_dest), int'(vecs[k].dest));
      pop_one();
    end

    // Level held across four ticks gives one entry
    mag = 5'h11; tp = 1'b1;
    repeat (4) clk_cycle(1'b1);
    tp = 1'b0;
    clk_cycle(1'b1);
    check("hold_count", int'(fifo_count), 1);
    check("hold_code", int'(char_code), 'h11);
    pop_one();

    // Nine characters into an 8-deep FIFO with no reader
    for (int i = 0; i < 9; i++) send_char(5'(i + 1), 1'b0, 1'b0, 1'b0);
    check("ovf_count", int'(fifo_count), DEPTH);
    check("ovf_flag", int'(overflow), 1);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_code", int'(char_code), i + 1);
      pop_one();
    end
    check("drain_empty", int'(char_valid), 0);
    check("ovf_sticky", int'(overflow), 1);
    do_reset();
    check("ovf_cleared", int'(overflow), 0);

    // Full FIFO with a pop on the push clock: no loss
    for (int i = 0; i < DEPTH; i++) send_char(5'(16 + i), 1'b0, 1'b0, 1'b0);
    check("full_count", int'(fifo_count), DEPTH);
    send_char(5'h1E, 1'b0, 1'b0, 1'b1);
    check("fullpop_count", int'(fifo_count), DEPTH);
    check("fullpop_overflow", int'(overflow), 0);
    check("fullpop_head", int'(char_code), 'h11);
    do_reset();

    // Reset while busy with three queued entries
    for (int i = 0; i < 3; i++) send_char(5'(5 + i), 1'b1, 1'b0, 1'b0);
    check("pre_rst_busy", int'(DEVICE_BUSY), 1);
    check("pre_rst_count", int'(fifo_count), 3);
    rst_n = 1'b0;
    clk_cycle(1'b0);
    check("midrst_busy", int'(DEVICE_BUSY), 0);
    check("midrst_valid", int'(char_valid), 0);
    check("midrst_count", int'(fifo_count), 0);
`ifdef SLOW_OUT_RX_CHAR_COUNT_EN
    check("midrst_total", int'(char_total), 0);
`endif
    rst_n = 1'b1;

    // Randomized traffic, reader speed varying by phase
    for (int i = 0; i < 2000; i++) begin
      int rdy_pct;
      rdy_pct = (i / 500) * 30;
      if (i == 1000) rst_n = 1'b0;
      else rst_n = 1'b1;
      if ($urandom_range(0, 3) == 0) tp = ~tp;
      mag = 5'($urandom_range(0, 31));
      punch = 1'($urandom_range(0, 1));
      card = ($urandom_range(0, 3) == 0);
      char_ready = ($urandom_range(0, 99) < rdy_pct);
      clk_cycle(1'($urandom_range(0, 1)));
    end
    rst_n = 1'b1;
    char_ready = 1'b0;
    tp = 1'b0;
    repeat (2) clk_cycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
